// File: rtl/moving_average_n.sv
// moving_average_n: running-mean filter over an N-tap sliding window
// (N = 2**LOG2_TAPS).
// A circular buffer holds the window and a running sum keeps the cost per
// sample constant. Z is the rounded mean (round half toward +inf), plus a
// window-full level and a per-update strobe. Empty slots read as zero, so
// during warm-up Z is the zero-padded mean.
module moving_average_n #(
  parameter int WIDTH     = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    enable_n,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] X,
  output logic signed [WIDTH-1:0] Z,
  output logic                    valid,
  output logic                    z_stb
);

  localparam int N       = 1 << LOG2_TAPS;
  localparam int SUM_W   = WIDTH + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] N_CNT = (LOG2_TAPS + 1)'(N);
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(N / 2);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_t;

  logic signed [WIDTH-1:0] window_mem [N];
  logic [LOG2_TAPS-1:0]    wp;
  logic signed [SUM_W-1:0] sum;
  logic [LOG2_TAPS:0]      cnt;

  fill_t                   fill_state;
  logic                    accept;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic signed [SUM_W-1:0] sum_next;
  logic [LOG2_TAPS:0]      cnt_next;
  logic signed [WIDTH-1:0] z_next;

  // Decode the fill state from the counter; FULL saturates the counter.
  always_comb begin
    fill_state = FILLING;
    if (cnt == '0)
      fill_state = EMPTY;
    else if (cnt == N_CNT)
      fill_state = FULL;
  end

  // Next-state datapath: swap the oldest sample out of the running sum and
  // round the mean with an arithmetic shift.
  always_comb begin
    accept   = ~enable_n & ~clear;
    x_ext    = {{LOG2_TAPS{X[WIDTH-1]}}, X};
    old_ext  = {{LOG2_TAPS{window_mem[wp][WIDTH-1]}}, window_mem[wp]};
    sum_next = sum + x_ext - old_ext;
    z_next   = WIDTH'((sum_next + HALF) >>> LOG2_TAPS);
    cnt_next = (fill_state == FULL) ? N_CNT : cnt + 1'b1;
  end

  // Window storage: zeroed on reset and clear, written at wp on each accepted sample.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++)
        window_mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++)
        window_mem[i] <= '0;
    end else if (accept) begin
      window_mem[wp] <= X;
    end
  end

  // Pointer, running sum, fill counter and the registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wp    <= '0;
      sum   <= '0;
      cnt   <= '0;
      Z     <= '0;
      valid <= 1'b0;
      z_stb <= 1'b0;
    end else if (clear) begin
      wp    <= '0;
      sum   <= '0;
      cnt   <= '0;
      Z     <= '0;
      valid <= 1'b0;
      z_stb <= 1'b0;
    end else if (accept) begin
      wp    <= wp + 1'b1;
      sum   <= sum_next;
      cnt   <= cnt_next;
      Z     <= z_next;
      valid <= (cnt_next == N_CNT);
      z_stb <= 1'b1;
    end else begin
      z_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_n.sv
// tb_moving_average_n: scoreboard bench for moving_average_n (WIDTH=8, N=4).
// Expected outputs come from the history of accepted samples since the last
// reset/clear, with the mean rounded by integer division and a floor fixup.
module tb_moving_average_n;

  localparam int WIDTH     = 8;
  localparam int LOG2_TAPS = 2;
  localparam int N         = 4;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic                    enable_n;
  logic                    clear;
  logic signed [WIDTH-1:0] X;
  logic signed [WIDTH-1:0] Z;
  logic                    valid;
  logic                    z_stb;

  typedef struct {
    int z;
    int v;
    int stb;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   total = 0;
  int   bad   = 0;

  moving_average_n #(.WIDTH(WIDTH), .LOG2_TAPS(LOG2_TAPS)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .enable_n(enable_n),
    .clear(clear),
    .X(X),
    .Z(Z),
    .valid(valid),
    .z_stb(z_stb)
  );

  // Free-running clock, period 10.
  always #5 Clk = ~Clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Rounded (half toward +inf) mean of the last N accepted samples, zero-padded.
  function automatic int expectedMean();
    int s;
    int num;
    int q;
    s = 0;
    for (int i = 0; i < hist.size(); i++)
      if (i >= hist.size() - N)
        s += hist[i];
    num = s + N / 2;
    q = num / N;
    if ((num % N) != 0 && num < 0)
      q = q - 1;
    return q;
  endfunction

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic applyStimulus(input logic en_n, input logic clr, input int x);
    exp_t e;
    enable_n = en_n;
    clear    = clr;
    X        = WIDTH'(x);
    if (clr)
      hist.delete();
    else if (!en_n)
      hist.push_back(x);
    e.z   = expectedMean();
    e.v   = (hist.size() >= N) ? 1 : 0;
    e.stb = (!clr && !en_n) ? 1 : 0;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    checkOutput("sb_z", int'(Z), e.z);
    checkOutput("sb_valid", int'(valid), e.v);
    checkOutput("sb_stb", int'(z_stb), e.stb);
  endtask

  // Asynchronous reset in mid-cycle; outputs must drop before any edge.
  task automatic resetMid();
    enable_n = 1'b1;
    clear    = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("rst_async_z", int'(Z), 0);
    checkOutput("rst_async_valid", int'(valid), 0);
    checkOutput("rst_async_stb", int'(z_stb), 0);
    hist.delete();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkOutput("rst_hold_z", int'(Z), 0);
  endtask

  initial begin
    int step_exp[4];
    int ext_exp[4];
    step_exp = '{10, 20, 30, 40};
    ext_exp  = '{63, 0, -64, -128};

    Reset = 1'b1; enable_n = 1'b1; clear = 1'b0; X = '0;
    #12;
    checkOutput("reset_z", int'(Z), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_stb", int'(z_stb), 0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Step fill and first eviction.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 40);
      checkOutput("step_z", int'(Z), step_exp[i]);
    end
    checkOutput("step_valid", int'(valid), 1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("step_evict_z", int'(Z), 30);

    // Async reset right after an accepted sample (z_stb was high).
    applyStimulus(1'b0, 1'b0, 7);
    resetMid();

    // Rounding cases.
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("round_pos", int'(Z), 1);
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("round_neg", int'(Z), 0);
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("round_quarter", int'(Z), 0);

    // Extremes.
    applyStimulus(1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 127);
    checkOutput("ext_max", int'(Z), 127);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, -128);
      checkOutput("ext_min_step", int'(Z), ext_exp[i]);
    end

    // Gaps, then clear colliding with a sample.
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 99);
      checkOutput("gap_z", int'(Z), 4);
    end
    applyStimulus(1'b0, 1'b1, 100);
    checkOutput("clr_prio_z", int'(Z), 0);
    checkOutput("clr_prio_valid", int'(valid), 0);

    // Ramp with wrap-around.
    for (int k = 0; k < 12; k++)
      applyStimulus(1'b0, 1'b0, k);
    checkOutput("ramp_z", int'(Z), 10);

    // Ramp interrupted by reset mid-stream, then resumed.
    applyStimulus(1'b1, 1'b1, 0);
    for (int k = 0; k < 7; k++)
      applyStimulus(1'b0, 1'b0, k);
    resetMid();
    for (int k = 7; k < 12; k++)
      applyStimulus(1'b0, 1'b0, k);
    checkOutput("ramp_rst_z", int'(Z), 10);

    // Random traffic with holds and occasional clears.
    for (int i = 0; i < 60; i++)
      applyStimulus(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                    int'($urandom_range(0, 255)) - 128);

    enable_n = 1'b1;
    clear    = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
